// File: rtl/he_seq_ctrl.sv
// he_seq_ctrl: frame sequencer for a histogram-equalisation datapath.
// Walks CLEAR -> HIST -> CDF -> LUT -> OUT -> DONE once per start request.
// Build option: define HE_SEQ_CLEAR_EN to include the CLEAR phase; when it is
// undefined, start goes straight to HIST and the datapath's reset clears bins.
module he_seq_ctrl #(
  parameter int unsigned IMAGE_WIDTH  = 660,
  parameter int unsigned IMAGE_HEIGHT = 440,
  parameter int unsigned NUM_BINS     = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       out_ready,
  output logic       out_valid,
  output logic       hist_clr,
  output logic       hist_inc,
  output logic       cdf_en,
  output logic       lut_we,
  output logic       map_en,
  output logic [7:0] bin_addr,
  output logic [2:0] phase,
  output logic       busy,
  output logic       done
);

  localparam int unsigned PIX_W      = 19;
  localparam int unsigned BIN_W      = 8;
  localparam int unsigned NUM_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;

  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_PIXELS - 1);
  localparam logic [PIX_W-1:0] FULL_PIX = PIX_W'(NUM_PIXELS);
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_HIST  = 3'd2;
  localparam logic [2:0] S_CDF   = 3'd3;
  localparam logic [2:0] S_LUT   = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]       r_state;
  logic [BIN_W-1:0] r_bin;
  logic [PIX_W-1:0] r_in_cnt;
  logic [PIX_W-1:0] r_out_cnt;
  logic             r_out_valid;

  logic [2:0]       w_state_nxt;
  logic [BIN_W-1:0] w_bin_nxt;
  logic [BIN_W-1:0] w_bin_step;
  logic [PIX_W-1:0] w_in_cnt_nxt;
  logic [PIX_W-1:0] w_out_cnt_nxt;
  logic             w_out_valid_nxt;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_out_hs;
  logic             w_bin_last;
  logic             w_in_full;

  assign w_bin_last = (r_bin == LAST_BIN);
  assign w_bin_step = w_bin_last ? '0 : r_bin + BIN_W'(1);
  assign w_in_full  = (r_in_cnt == FULL_PIX);
  assign w_accept   = in_valid & w_in_ready;
  assign w_out_hs   = r_out_valid & out_ready;

  // Upstream ready: always open in HIST, in OUT only while the output slot can drain
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      S_HIST:  w_in_ready = 1'b1;
      S_OUT:   w_in_ready = (out_ready | ~r_out_valid) & ~w_in_full;
      default: w_in_ready = 1'b0;
    endcase
  end

  // Next-state, bin address, pixel counters and output-valid update
  always_comb begin
    w_state_nxt     = r_state;
    w_bin_nxt       = r_bin;
    w_in_cnt_nxt    = r_in_cnt;
    w_out_cnt_nxt   = r_out_cnt;
    w_out_valid_nxt = r_out_valid;
    case (r_state)
      S_IDLE: begin
        w_bin_nxt = '0;
        if (start) begin
`ifdef HE_SEQ_CLEAR_EN
          w_state_nxt = S_CLEAR;
`else
          w_state_nxt = S_HIST;
`endif
        end
      end
      S_CLEAR: begin
        w_bin_nxt = w_bin_step;
        if (w_bin_last) w_state_nxt = S_HIST;
      end
      S_HIST: begin
        if (w_accept) begin
          if (r_in_cnt == LAST_PIX) begin
            w_state_nxt  = S_CDF;
            w_in_cnt_nxt = '0;
          end else begin
            w_in_cnt_nxt = r_in_cnt + PIX_W'(1);
          end
        end
      end
      S_CDF: begin
        w_bin_nxt = w_bin_step;
        if (w_bin_last) w_state_nxt = S_LUT;
      end
      S_LUT: begin
        w_bin_nxt = w_bin_step;
        if (w_bin_last) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        // LUT read takes one cycle, so a new map_en refills the output slot next cycle
        if (w_accept) begin
          w_in_cnt_nxt    = r_in_cnt + PIX_W'(1);
          w_out_valid_nxt = 1'b1;
        end else if (out_ready) begin
          w_out_valid_nxt = 1'b0;
        end
        if (w_out_hs) begin
          if (r_out_cnt == LAST_PIX) begin
            w_state_nxt     = S_DONE;
            w_in_cnt_nxt    = '0;
            w_out_cnt_nxt   = '0;
            w_out_valid_nxt = 1'b0;
          end else begin
            w_out_cnt_nxt = r_out_cnt + PIX_W'(1);
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_bin_nxt       = '0;
        w_in_cnt_nxt    = '0;
        w_out_cnt_nxt   = '0;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and datapath-control registers, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bin       <= '0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bin       <= w_bin_nxt;
      r_in_cnt    <= w_in_cnt_nxt;
      r_out_cnt   <= w_out_cnt_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
`ifdef HE_SEQ_CLEAR_EN
  assign hist_clr  = (r_state == S_CLEAR);
`else
  assign hist_clr  = 1'b0;
`endif
  assign hist_inc  = (r_state == S_HIST) & in_valid;
  assign cdf_en    = (r_state == S_CDF);
  assign lut_we    = (r_state == S_LUT);
  assign map_en    = (r_state == S_OUT) & w_accept;
  assign bin_addr  = r_bin;
  assign phase     = r_state;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule
